// File: rtl/cw305_burst_ctrl.sv
// cw305_burst_ctrl: single-outstanding OBI word-burst sequencer driving an external +4 address counter
module cw305_burst_ctrl #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             wr,
    input  logic [31:0]      base_addr,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    input  logic [31:0]      wdata_i,
    input  logic             wvalid_i,
    output logic             wready_o,
    output logic [31:0]      rdata_o,
    output logic             rvalid_o,
    output logic             cnt_load_o,
    output logic             cnt_en_o,
    output logic [31:0]      cnt_in_o,
    input  logic [31:0]      cnt_out_i,
    output logic             bus_req_o,
    input  logic             bus_gnt_i,
    output logic             bus_we_o,
    output logic [3:0]       bus_be_o,
    output logic [31:0]      bus_addr_o,
    output logic [31:0]      bus_wdata_o,
    input  logic             bus_rvalid_i,
    input  logic [31:0]      bus_rdata_i
);
    typedef enum logic [2:0] {IDLE, WDATA, REQ, RESP, DONE} state_t;
    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);
    state_t           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             wr_q, wr_d, abort_q, abort_d, rvalid_q, rvalid_d;
    logic [31:0]      wdata_q, wdata_d, rdata_q, rdata_d;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            wr_q     <= 1'b0;
            abort_q  <= 1'b0;
            rvalid_q <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            wr_q     <= wr_d;
            abort_q  <= abort_d;
            rvalid_q <= rvalid_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        wr_d       = wr_q;
        abort_d    = abort_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
        cnt_load_o = 1'b0;
        cnt_en_o   = 1'b0;
        wready_o   = 1'b0;
        bus_req_o  = 1'b0;
        case (state_q)
            IDLE: if (start && !abort) begin
                cnt_load_o = 1'b1;
                wr_d       = wr;
                rem_d      = len;
                abort_d    = 1'b0;
                state_d    = (len == '0) ? DONE : wr ? WDATA : REQ;
            end
            WDATA: begin
                wready_o = !abort;
                if (abort) begin
                    abort_d = 1'b1;
                    state_d = DONE;
                end else if (wvalid_i) begin
                    wdata_d = wdata_i;
                    state_d = REQ;
                end
            end
            REQ: begin
                bus_req_o = 1'b1;
                abort_d   = abort_q | abort;
                state_d   = bus_gnt_i ? RESP : REQ;
            end
            RESP: if (bus_rvalid_i) begin
                // an abort arriving with the final response does not mark the burst aborted
                cnt_en_o = 1'b1;
                rem_d    = rem_q - ONE;
                rvalid_d = !wr_q;
                rdata_d  = wr_q ? rdata_q : bus_rdata_i;
                abort_d  = (rem_q == ONE) ? abort_q : (abort_q | abort);
                state_d  = (rem_q == ONE || abort_q || abort) ? DONE : wr_q ? WDATA : REQ;
            end else begin
                abort_d = abort_q | abort;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    assign busy        = state_q != IDLE;
    assign done        = state_q == DONE;
    assign aborted     = done & abort_q;
    assign rdata_o     = rdata_q;
    assign rvalid_o    = rvalid_q;
    assign cnt_in_o    = cnt_load_o ? (base_addr & 32'hFFFF_FFFC) : '0;
    assign bus_we_o    = (state_q == REQ) & wr_q;
    assign bus_be_o    = 4'hF;
    assign bus_addr_o  = (state_q == REQ) ? cnt_out_i : '0;
    assign bus_wdata_o = bus_we_o ? wdata_q : '0;
endmodule

// File: tb/tb_cw305_burst_ctrl.sv
// tb_cw305_burst_ctrl: transaction-level reference model with a per-cycle output compare
module tb_cw305_burst_ctrl;
    localparam int LEN_W = 8;
    logic             clk = 0, rst = 1, start = 0, wr = 0, abort = 0, wvalid_i = 0;
    logic             bus_gnt_i = 0, bus_rvalid_i = 0;
    logic [31:0]      base_addr = 0, wdata_i = 0, bus_rdata_i = 0;
    logic [LEN_W-1:0] len = 0;
    logic             busy, done, aborted, wready_o, rvalid_o, cnt_load_o, cnt_en_o;
    logic             bus_req_o, bus_we_o;
    logic [3:0]       bus_be_o;
    logic [31:0]      rdata_o, cnt_in_o, bus_addr_o, bus_wdata_o, cnt_q;
    logic             rst_n;
    cw305_burst_ctrl #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .wr(wr), .base_addr(base_addr), .len(len),
        .abort(abort), .busy(busy), .done(done), .aborted(aborted),
        .wdata_i(wdata_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
        .rdata_o(rdata_o), .rvalid_o(rvalid_o),
        .cnt_load_o(cnt_load_o), .cnt_en_o(cnt_en_o), .cnt_in_o(cnt_in_o), .cnt_out_i(cnt_q),
        .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
    );
    always #5 clk = ~clk;
    assign rst_n = ~rst;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else if (cnt_load_o) cnt_q <= cnt_in_o;
        else if (cnt_en_o) cnt_q <= cnt_q + 32'd4;

    int n_vec = 0, n_err = 0, cyc = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Burst model: progress is counted in words; the address is plain base + 4*index.
    bit        m_active, m_done_p, m_dab, m_wr, m_abs, m_have, m_granted, m_rvp;
    logic [31:0] m_base, m_word, m_rdata;
    int        m_len, m_idx, m_age;
    logic [2:0] m_ph;
    function automatic bit f_req();
        return m_active && !m_done_p && !m_granted && (!m_wr || m_have);
    endfunction
    function automatic bit f_wword();
        return m_active && !m_done_p && !m_granted && m_wr && !m_have;
    endfunction
    task automatic model_step();
        bit nrv;
        logic [2:0] ph;
        nrv = 0;
        if (m_done_p) begin
            m_done_p = 0;
            m_active = 0;
        end else if (!m_active) begin
            if (start && !abort) begin
                m_active = 1; m_base = base_addr & 32'hFFFF_FFFC; m_len = int'(len); m_wr = wr;
                m_idx = 0; m_abs = 0; m_have = 0; m_granted = 0; m_dab = 0;
                if (m_len == 0) m_done_p = 1;
            end
        end else if (m_granted) begin
            if (bus_rvalid_i) begin
                m_granted = 0; m_idx++; m_have = 0;
                if (!m_wr) begin nrv = 1; m_rdata = bus_rdata_i; end
                if (m_idx == m_len) begin m_done_p = 1; m_dab = m_abs; end
                else if (m_abs || abort) begin m_done_p = 1; m_dab = 1; end
            end else m_abs = m_abs | abort;
        end else if (m_wr && !m_have) begin
            if (abort) begin m_done_p = 1; m_dab = 1; end
            else if (wvalid_i) begin m_have = 1; m_word = wdata_i; end
        end else begin
            m_abs = m_abs | abort;
            if (bus_gnt_i) m_granted = 1;
        end
        m_rvp = nrv;
        ph = {f_req(), m_granted, f_wword()};
        m_age = (ph == m_ph) ? m_age + 1 : 0;
        m_ph = ph;
    endtask
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_active = 0; m_done_p = 0; m_dab = 0; m_wr = 0; m_abs = 0; m_have = 0;
            m_granted = 0; m_rvp = 0; m_idx = 0; m_len = 0; m_age = 0; m_ph = 0;
        end else begin
            cyc++;
            model_step();
        end
    end

    bit rnd = 0;
    int gnt_dly = 0, rv_dly = 0, wv_dly = 0, abort_word = -1;
    initial forever begin
        @(posedge clk); #1;
        bus_rdata_i = $urandom; wdata_i = $urandom;
        if (rnd) begin
            start = ($urandom % 4) == 0; base_addr = $urandom; wr = $urandom % 2;
            len = (($urandom % 16) == 0) ? LEN_W'($urandom) : LEN_W'($urandom % 6);
            abort = ($urandom % 100) < 3;
            bus_gnt_i = f_req() ? ($urandom % 2 == 1) : ($urandom % 8 == 0);
            bus_rvalid_i = m_granted ? ($urandom % 3 == 0) : ($urandom % 16 == 0);
            wvalid_i = $urandom % 2;
        end else begin
            bus_gnt_i = f_req() && m_age >= gnt_dly;
            bus_rvalid_i = m_granted && m_age >= rv_dly;
            wvalid_i = f_wword() && m_age >= wv_dly;
            abort = abort_word >= 0 && m_granted && m_idx == abort_word && m_age == 0;
        end
    end

    logic [31:0] q_addr[$], q_wd[$], q_hw[$];
    int n_en, n_load, n_rv, n_done, n_reqc, load_cyc, rv_cyc, done_cyc;
    bit last_ab, p_req, p_gnt, p_we;
    logic [31:0] p_addr, p_wd;
    task automatic clr_mon();
        q_addr.delete(); q_wd.delete(); q_hw.delete();
        n_en = 0; n_load = 0; n_rv = 0; n_done = 0; n_reqc = 0;
        load_cyc = 0; rv_cyc = -1; done_cyc = 0; last_ab = 0;
    endtask
    initial forever begin
        @(negedge clk);
        chk("busy", busy, m_active);
        chk("done", done, m_done_p);
        chk("aborted", aborted, m_done_p & m_dab);
        chk("cnt_load", cnt_load_o, !m_active && start && !abort);
        chk("cnt_in", cnt_in_o, (!m_active && start && !abort) ? (base_addr & 32'hFFFF_FFFC) : 32'h0);
        chk("cnt_en", cnt_en_o, m_granted && bus_rvalid_i);
        chk("load_en_excl", cnt_load_o & cnt_en_o, 0);
        chk("wready", wready_o, f_wword() && !abort);
        chk("bus_req", bus_req_o, f_req());
        chk("bus_we", bus_we_o, f_req() && m_wr);
        chk("bus_be", bus_be_o, 4'hF);
        chk("bus_addr", bus_addr_o, f_req() ? m_base + 32'(m_idx * 4) : 32'h0);
        chk("bus_wdata", bus_wdata_o, (f_req() && m_wr) ? m_word : 32'h0);
        chk("rvalid_o", rvalid_o, m_rvp);
        if (m_rvp) chk("rdata_o", rdata_o, m_rdata);
        if (p_req && !p_gnt && !rst) begin
            chk("req_held", bus_req_o, 1);
            chk("addr_held", bus_addr_o, p_addr);
            chk("we_held", bus_we_o, p_we);
            chk("wdata_held", bus_wdata_o, p_wd);
        end
        p_req = bus_req_o; p_gnt = bus_gnt_i; p_addr = bus_addr_o; p_we = bus_we_o; p_wd = bus_wdata_o;
        if (bus_req_o) n_reqc++;
        if (bus_req_o && bus_gnt_i) begin q_addr.push_back(bus_addr_o); q_wd.push_back(bus_wdata_o); end
        if (wvalid_i && wready_o) q_hw.push_back(wdata_i);
        if (cnt_en_o) n_en++;
        if (cnt_load_o) begin n_load++; load_cyc = cyc; end
        if (rvalid_o) begin n_rv++; rv_cyc = cyc; end
        if (done) begin n_done++; done_cyc = cyc; last_ab = aborted; end
    end

    task automatic kick(input logic [31:0] b, input int l, input bit w);
        clr_mon();
        @(posedge clk); #2;
        start = 1; base_addr = b; len = LEN_W'(l); wr = w;
        @(posedge clk); #2;
        start = 0;
    endtask
    task automatic burst(input logic [31:0] b, input int l, input bit w);
        kick(b, l, w);
        for (int t = 0; t < 400 && n_done == 0; t++) begin @(negedge clk); #1; end
        chk("burst_finished", n_done, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_req", bus_req_o, 0);
        chk("rst_be", bus_be_o, 4'hF);
        chk("rst_rdata", rdata_o, 0);
        @(negedge clk); #2 rst = 0;
        burst(32'h1003, 3, 0);
        chk("t1_n", q_addr.size(), 3);
        chk("t1_a0", q_addr[0], 32'h1000);
        chk("t1_a1", q_addr[1], 32'h1004);
        chk("t1_a2", q_addr[2], 32'h1008);
        chk("t1_nrv", n_rv, 3);
        chk("t1_lat", done_cyc - load_cyc, 7);
        chk("t1_rv_done", rv_cyc, done_cyc);
        chk("t1_ab", last_ab, 0);
        gnt_dly = 2; wv_dly = 4;
        burst(32'h20, 2, 1);
        chk("t2_n", q_addr.size(), 2);
        chk("t2_a0", q_addr[0], 32'h20);
        chk("t2_a1", q_addr[1], 32'h24);
        chk("t2_nhw", q_hw.size(), 2);
        chk("t2_wd0", q_wd[0], q_hw[0]);
        chk("t2_wd1", q_wd[1], q_hw[1]);
        chk("t2_en", n_en, 2);
        chk("t2_reqc", n_reqc, 6);
        gnt_dly = 0; wv_dly = 0;
        burst(32'h40, 0, 0);
        chk("t3_load", n_load, 1);
        chk("t3_reqc", n_reqc, 0);
        chk("t3_lat", done_cyc - load_cyc, 1);
        rv_dly = 2; abort_word = 1;
        burst(32'h100, 5, 0);
        chk("t4_n", q_addr.size(), 2);
        chk("t4_ab", last_ab, 1);
        chk("t4_en", n_en, 2);
        chk("t4_nrv", n_rv, 2);
        rv_dly = 0; abort_word = -1;
        burst(32'hFFFF_FFF8, 3, 0);
        chk("t5_n", q_addr.size(), 3);
        chk("t5_a0", q_addr[0], 32'hFFFF_FFF8);
        chk("t5_a1", q_addr[1], 32'hFFFF_FFFC);
        chk("t5_a2", q_addr[2], 32'h0);
        gnt_dly = 5;
        kick(32'h300, 3, 0);
        for (int t = 0; t < 20 && !bus_req_o; t++) begin @(negedge clk); #1; end
        chk("t6_req_seen", bus_req_o, 1);
        #1 rst = 1;
        #1;
        chk("t6_req_drop", bus_req_o, 0);
        chk("t6_busy_drop", busy, 0);
        chk("t6_done_drop", done, 0);
        @(negedge clk); #2 rst = 0;
        gnt_dly = 0;
        burst(32'h500, 2, 0);
        chk("t6_n", q_addr.size(), 2);
        chk("t6_a0", q_addr[0], 32'h500);
        chk("t6_a1", q_addr[1], 32'h504);
        chk("t6_nrv", n_rv, 2);
        rnd = 1;
        repeat (4000) @(posedge clk);
        rnd = 0;
        #2 start = 0; abort = 0;
        for (int t = 0; t < 2000 && busy; t++) begin @(negedge clk); #1; end
        chk("drain_idle", busy, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
